// File: rtl/sram_1rw_param.sv
// sram_1rw_param: parametrised 1RW SRAM model with valid/ready requests, registered read response and power-on clear sweep.
// Optional per-group even parity with an injection port is enabled by defining SRAM_PARITY_EN.
module sram_1rw_param #(
    parameter int DATA_WIDTH = 32,
    parameter int MASK_GRAN = 8,
    parameter int SPARE_BITS = 1,
    parameter int DEPTH = 512,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter bit CLEAR_ON_RESET = 1'b1,
    localparam int NUM_WMASKS = DATA_WIDTH / MASK_GRAN,
    localparam int WORD_WIDTH = DATA_WIDTH + SPARE_BITS
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic                  req_spare_wen,
    input  logic [WORD_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [WORD_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  init_done
`ifdef SRAM_PARITY_EN
    ,
    input  logic                  parity_inject
`endif
);
    typedef enum logic {INIT, READY} state_t;
    state_t state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [WORD_WIDTH-1:0] ben, rd_word;
    logic acc, rd, in_range, par_err;
    assign acc = req_valid && req_ready;
    assign rd = acc && !req_we;
    assign in_range = 32'(req_addr) < DEPTH;
    assign rd_word = in_range ? mem[req_addr] : '0;
    // Per-bit write enable: data bits follow their mask group, spare bits follow spare_wen
    for (genvar i = 0; i < WORD_WIDTH; i++) begin : g_ben
        if (i < DATA_WIDTH) begin : g_data
            assign ben[i] = req_wmask[i / MASK_GRAN];
        end else begin : g_spare
            assign ben[i] = req_spare_wen;
        end
    end
    always_ff @(posedge clk0) begin
        if (rst0_n && state == INIT) mem[cnt] <= '0;
        else if (acc && req_we && in_range) mem[req_addr] <= (mem[req_addr] & ~ben) | (req_wdata & ben);
    end
`ifdef SRAM_PARITY_EN
    logic [NUM_WMASKS-1:0] par_mem [DEPTH];
    logic [NUM_WMASKS-1:0] wpar, rpar;
    for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_par
        assign wpar[i] = ^req_wdata[i*MASK_GRAN +: MASK_GRAN] ^ parity_inject;
        assign rpar[i] = ^rd_word[i*MASK_GRAN +: MASK_GRAN];
    end
    assign par_err = in_range && (rpar != par_mem[req_addr]);
    always_ff @(posedge clk0) begin
        if (rst0_n && state == INIT) par_mem[cnt] <= '0;
        else if (acc && req_we && in_range) par_mem[req_addr] <= (par_mem[req_addr] & ~req_wmask) | (wpar & req_wmask);
    end
`else
    assign par_err = 1'b0;
`endif
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state <= CLEAR_ON_RESET ? INIT : READY;
            req_ready <= !CLEAR_ON_RESET;
            init_done <= !CLEAR_ON_RESET;
            cnt <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
        end else begin
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
                if (cnt == ADDR_WIDTH'(DEPTH - 1)) begin
                    state <= READY;
                    req_ready <= 1'b1;
                    init_done <= 1'b1;
                end
            end
            rsp_valid <= rd;
            rsp_err <= rd && (!in_range || par_err);
            if (rd) rsp_rdata <= rd_word;
        end
    end
endmodule
